// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit.
//   lsu_size_e   : access size encoding (B/H/W/D)
//   lsu_state_e  : bus handshake FSM states
//   lsu_size_mask: byte mask of an access starting at lane 0
`timescale 1ns/1ps
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'b00,
        LSU_SIZE_H = 2'b01,
        LSU_SIZE_W = 2'b10,
        LSU_SIZE_D = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        RVALID = 2'b10
    } lsu_state_e;

    function automatic logic [7:0] lsu_size_mask(input lsu_size_e size);
        case (size)
            LSU_SIZE_B: lsu_size_mask = 8'h01;
            LSU_SIZE_H: lsu_size_mask = 8'h03;
            LSU_SIZE_W: lsu_size_mask = 8'h0F;
            default:    lsu_size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_data_align.sv
// Combinational lane handling for the LSU.
//   Request side : req_size_i/req_off_i/wdata_i -> be_o, wdata_o, misaligned_o
//   Response side: rsp_size_i/rsp_off_i/rsp_unsigned_i/rdata_i -> rdata_o
//                  (lane-extracted, truncated, sign/zero extended)
`timescale 1ns/1ps
module mem_stage_lsu_data_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int BE_WIDTH  = DATA_WIDTH / 8,
    localparam int OFF_W     = $clog2(BE_WIDTH)
) (
    input  lsu_size_e              req_size_i,
    input  logic [OFF_W-1:0]       req_off_i,
    input  logic [DATA_WIDTH-1:0]  wdata_i,
    output logic [BE_WIDTH-1:0]    be_o,
    output logic [DATA_WIDTH-1:0]  wdata_o,
    output logic                   misaligned_o,
    input  lsu_size_e              rsp_size_i,
    input  logic [OFF_W-1:0]       rsp_off_i,
    input  logic                   rsp_unsigned_i,
    input  logic [DATA_WIDTH-1:0]  rdata_i,
    output logic [DATA_WIDTH-1:0]  rdata_o
);

    logic [DATA_WIDTH-1:0] rdata_sh;
    logic [DATA_WIDTH-1:0] dmask;
    logic [7:0]            rsp_bmask;
    logic                  sign;

    always_comb begin
        be_o    = BE_WIDTH'(lsu_size_mask(req_size_i)) << req_off_i;
        wdata_o = wdata_i << {req_off_i, 3'b000};
        case (req_size_i)
            LSU_SIZE_B: misaligned_o = 1'b0;
            LSU_SIZE_H: misaligned_o = req_off_i[0];
            LSU_SIZE_W: misaligned_o = (req_off_i[1:0] != 2'b00);
            // Dword only exists on a 64-bit datapath
            default:    misaligned_o = (DATA_WIDTH != 64) || (req_off_i != '0);
        endcase
    end

    // Extension is done by masking the valid bytes and filling the rest with
    // the sign bit, which avoids zero-width replications on the 32-bit build.
    always_comb begin
        rdata_sh  = rdata_i >> {rsp_off_i, 3'b000};
        rsp_bmask = lsu_size_mask(rsp_size_i);
        dmask     = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            dmask[8*i +: 8] = {8{rsp_bmask[i]}};
        end
        case (rsp_size_i)
            LSU_SIZE_B: sign = rdata_sh[7];
            LSU_SIZE_H: sign = rdata_sh[15];
            LSU_SIZE_W: sign = rdata_sh[31];
            default:    sign = 1'b0;
        endcase
        rdata_o = (rdata_sh & dmask)
                | ({DATA_WIDTH{sign & ~rsp_unsigned_i}} & ~dmask);
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: accepts one op from EX, runs the data-memory
// req/gnt/rvalid handshake and presents a registered one-cycle result to WB.
//   EX side : valid_i/ready_o, flush_i, load_i, store_i, size_i, unsigned_i,
//             addr_i, wdata_i, alu_result_i
//   WB side : valid_o, result_o, misaligned_o
//   Bus side: data_req_o/data_gnt_i/data_rvalid_i, data_addr_o, data_we_o,
//             data_be_o, data_wdata_o, data_rdata_i
`timescale 1ns/1ps
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  flush_i,
    input  logic                  load_i,
    input  logic                  store_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  misaligned_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [BE_WIDTH-1:0]   data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic [DATA_WIDTH-1:0] data_rdata_i
);

    localparam int OFF_W = $clog2(BE_WIDTH);

    lsu_state_e            state_q;
    lsu_size_e             size_q;
    logic [OFF_W-1:0]      off_q;
    logic                  unsigned_q;
    logic                  kill_q;      // load flushed after gnt: absorb rvalid silently
    logic                  accept;
    logic                  misaligned;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] rdata_ext;

    assign ready_o = (state_q == IDLE);
    assign accept  = valid_i & ready_o & ~flush_i;

    mem_stage_lsu_data_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .req_size_i     (lsu_size_e'(size_i)),
        .req_off_i      (addr_i[OFF_W-1:0]),
        .wdata_i        (wdata_i),
        .be_o           (be),
        .wdata_o        (wdata_sh),
        .misaligned_o   (misaligned),
        .rsp_size_i     (size_q),
        .rsp_off_i      (off_q),
        .rsp_unsigned_i (unsigned_q),
        .rdata_i        (data_rdata_i),
        .rdata_o        (rdata_ext)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            size_q       <= LSU_SIZE_B;
            off_q        <= '0;
            unsigned_q   <= 1'b0;
            kill_q       <= 1'b0;
            valid_o      <= 1'b0;
            misaligned_o <= 1'b0;
            result_o     <= '0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_addr_o  <= '0;
            data_be_o    <= '0;
            data_wdata_o <= '0;
        end else begin
            valid_o      <= 1'b0;
            misaligned_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!(load_i | store_i)) begin
                            valid_o  <= 1'b1;
                            result_o <= alu_result_i;
                        end else if (misaligned) begin
                            valid_o      <= 1'b1;
                            misaligned_o <= 1'b1;
                            result_o     <= '0;
                        end else begin
                            state_q      <= REQ;
                            data_req_o   <= 1'b1;
                            data_we_o    <= store_i;
                            data_addr_o  <= {addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            data_be_o    <= be;
                            data_wdata_o <= wdata_sh;
                            size_q       <= lsu_size_e'(size_i);
                            off_q        <= addr_i[OFF_W-1:0];
                            unsigned_q   <= unsigned_i;
                            kill_q       <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (data_gnt_i) begin
                        // Granted: the bus beat completes even if flushed now
                        data_req_o <= 1'b0;
                        if (data_we_o) begin
                            state_q <= IDLE;
                            if (!flush_i) begin
                                valid_o  <= 1'b1;
                                result_o <= '0;
                            end
                        end else begin
                            state_q <= RVALID;
                            kill_q  <= flush_i;
                        end
                    end else if (flush_i) begin
                        data_req_o <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                RVALID: begin
                    if (data_rvalid_i) begin
                        state_q <= IDLE;
                        if (!(kill_q | flush_i)) begin
                            valid_o  <= 1'b1;
                            result_o <= rdata_ext;
                        end
                    end else if (flush_i) begin
                        kill_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
module tb_mem_stage_lsu;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic rst_ni;

    // 32-bit instance
    logic        valid_i, flush_i, load_i, store_i, unsigned_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i, alu_result_i;
    logic        ready_o, valid_o, misaligned_o;
    logic [31:0] result_o;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;

    // 64-bit instance
    logic        valid_w, flush_w, load_w, store_w, unsigned_w;
    logic [1:0]  size_w;
    logic [31:0] addr_w;
    logic [63:0] wdata_w, alu_w;
    logic        ready_w, valid_ow, mis_w;
    logic [63:0] result_w;
    logic        req_w, gnt_w, rvalid_w, we_w;
    logic [31:0] daddr_w;
    logic [63:0] dwdata_w, rdata_w;
    logic [7:0]  be_w;

    mem_stage_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .flush_i(flush_i), .load_i(load_i), .store_i(store_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .alu_result_i(alu_result_i), .valid_o(valid_o), .result_o(result_o),
        .misaligned_o(misaligned_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
    );

    mem_stage_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_w), .ready_o(ready_w),
        .flush_i(flush_w), .load_i(load_w), .store_i(store_w), .size_i(size_w),
        .unsigned_i(unsigned_w), .addr_i(addr_w), .wdata_i(wdata_w),
        .alu_result_i(alu_w), .valid_o(valid_ow), .result_o(result_w),
        .misaligned_o(mis_w), .data_req_o(req_w), .data_gnt_i(gnt_w),
        .data_rvalid_i(rvalid_w), .data_addr_o(daddr_w), .data_we_o(we_w),
        .data_be_o(be_w), .data_wdata_o(dwdata_w), .data_rdata_i(rdata_w)
    );

    int n_vec = 0;
    int n_err = 0;

    // Expected WB responses: {misaligned, result}
    logic [64:0] q32[$];
    logic [64:0] q64[$];
    logic [64:0] e32, e64;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && valid_o === 1'b1) begin
            if (q32.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid32: result 0x%0h, none expected", result_o);
            end else begin
                e32 = q32.pop_front();
                check("result32", 64'(result_o), e32[63:0]);
                check("misaligned32", 64'(misaligned_o), 64'(e32[64]));
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && valid_ow === 1'b1) begin
            if (q64.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid64: result 0x%0h, none expected", result_w);
            end else begin
                e64 = q64.pop_front();
                check("result64", result_w, e64[63:0]);
                check("misaligned64", 64'(mis_w), 64'(e64[64]));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] alu);
        int n = 0;
        while (ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) timeout("issue_ready");
        valid_i = 1'b1; load_i = ld; store_i = st; size_i = sz; unsigned_i = uns;
        addr_i = a; wdata_i = wd; alu_result_i = alu;
        tick();
        valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
    endtask

    task automatic bus(input logic [31:0] ea, input logic ewe, input logic [3:0] ebe,
                       input logic [31:0] ewd, input int gw, input int rw,
                       input logic [31:0] rd, output int rdy_low);
        int   n = 0;
        logic held = 1'b1;
        rdy_low = 0;
        while (data_req_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            timeout("bus_req");
            return;
        end
        check("bus_addr", 64'(data_addr_o), 64'(ea));
        check("bus_we", 64'(data_we_o), 64'(ewe));
        check("bus_be", 64'(data_be_o), 64'(ebe));
        check("bus_wdata", 64'(data_wdata_o), 64'(ewd));
        repeat (gw) begin
            if (ready_o === 1'b0) rdy_low++;
            held = held & data_req_o & (data_addr_o == ea) & (data_be_o == ebe)
                 & (data_wdata_o == ewd);
            tick();
        end
        if (ready_o === 1'b0) rdy_low++;
        check("req_held", 64'(held & data_req_o), 64'(1));
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        check("req_dropped", 64'(data_req_o), 64'(0));
        if (!ewe) begin
            repeat (rw) tick();
            data_rvalid_i = 1'b1;
            data_rdata_i  = rd;
            tick();
            data_rvalid_i = 1'b0;
        end
        check("ready_after", 64'(ready_o), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rl;
        rst_ni = 1'b0;
        valid_i = 0; flush_i = 0; load_i = 0; store_i = 0; unsigned_i = 0; size_i = 0;
        addr_i = 0; wdata_i = 0; alu_result_i = 0;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
        valid_w = 0; flush_w = 0; load_w = 0; store_w = 0; unsigned_w = 0; size_w = 0;
        addr_w = 0; wdata_w = 0; alu_w = 0; gnt_w = 0; rvalid_w = 0; rdata_w = 0;
        tick();
        tick();
        check("rst_valid", 64'(valid_o), 64'(0));
        check("rst_req", 64'(data_req_o), 64'(0));
        check("rst_ready", 64'(ready_o), 64'(1));
        check("rst_result", 64'(result_o), 64'(0));
        check("rst_be", 64'(data_be_o), 64'(0));
        rst_ni = 1'b1;
        tick();

        // Non-memory op
        q32.push_back({1'b0, 64'h1234});
        issue(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h1234);
        check("alu_no_req", 64'(data_req_o), 64'(0));

        // SB 0xAB @0x103, gnt after 3 waits
        q32.push_back({1'b0, 64'h0});
        issue(0, 1, 2'b00, 0, 32'h103, 32'hAB, 32'h0);
        bus(32'h100, 1, 4'b1000, 32'hAB00_0000, 3, 0, 0, rl);
        check("sb_ready_low_cycles", 64'(rl), 64'(4));

        // SH 0x1234 @0x2
        q32.push_back({1'b0, 64'h0});
        issue(0, 1, 2'b01, 0, 32'h2, 32'h1234, 32'h0);
        bus(32'h0, 1, 4'b1100, 32'h1234_0000, 1, 0, 0, rl);

        // LB / LBU @0x101
        q32.push_back({1'b0, 64'hFFFF_FF80});
        issue(1, 0, 2'b00, 0, 32'h101, 32'h0, 32'h0);
        bus(32'h100, 0, 4'b0010, 32'h0, 0, 1, 32'h0000_8000, rl);
        q32.push_back({1'b0, 64'h0000_0080});
        issue(1, 0, 2'b00, 1, 32'h101, 32'h0, 32'h0);
        bus(32'h100, 0, 4'b0010, 32'h0, 0, 0, 32'h0000_8000, rl);

        // LH @0x2
        q32.push_back({1'b0, 64'hFFFF_8001});
        issue(1, 0, 2'b01, 0, 32'h2, 32'h0, 32'h0);
        bus(32'h0, 0, 4'b1100, 32'h0, 1, 2, 32'h8001_0000, rl);

        // LW aligned
        q32.push_back({1'b0, 64'hDEAD_BEEF});
        issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0);
        bus(32'h10, 0, 4'b1111, 32'h0, 0, 0, 32'hDEAD_BEEF, rl);

        // Misaligned: LW @0x102, SH @0x1, SD on 32-bit
        q32.push_back({1'b1, 64'h0});
        issue(1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h0);
        check("mis_lw_no_req0", 64'(data_req_o), 64'(0));
        tick();
        check("mis_lw_no_req1", 64'(data_req_o), 64'(0));
        q32.push_back({1'b1, 64'h0});
        issue(0, 1, 2'b01, 0, 32'h1, 32'h55, 32'h0);
        check("mis_sh_no_req", 64'(data_req_o), 64'(0));
        q32.push_back({1'b1, 64'h0});
        issue(0, 1, 2'b11, 0, 32'h0, 32'h55, 32'h0);
        check("mis_sd32_no_req", 64'(data_req_o), 64'(0));

        // Load, gnt, flush during RVALID, rvalid 2 cycles later
        issue(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0);
        check("fl_rv_req", 64'(data_req_o), 64'(1));
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fl_rv_ready_low", 64'(ready_o), 64'(0));
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h5555_5555;
        tick();
        data_rvalid_i = 1'b0;
        check("fl_rv_ready_back", 64'(ready_o), 64'(1));
        q32.push_back({1'b0, 64'hBEEF});
        issue(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'hBEEF);

        // Flush in REQ before gnt
        issue(0, 1, 2'b10, 0, 32'h40, 32'h1, 32'h0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fl_req_dropped", 64'(data_req_o), 64'(0));
        check("fl_req_idle", 64'(ready_o), 64'(1));

        // Flush together with gnt: bus completes, no WB
        issue(0, 1, 2'b10, 0, 32'h44, 32'h2, 32'h0);
        data_gnt_i = 1'b1;
        flush_i    = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        flush_i    = 1'b0;
        check("fl_gnt_req_low", 64'(data_req_o), 64'(0));
        check("fl_gnt_idle", 64'(ready_o), 64'(1));

        // Flush in IDLE drops the incoming op
        valid_i = 1'b1; alu_result_i = 32'h77; flush_i = 1'b1;
        tick();
        valid_i = 1'b0; flush_i = 1'b0;
        tick();
        q32.push_back({1'b0, 64'h99});
        issue(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h99);
        tick();

        // Reset while in REQ
        issue(0, 1, 2'b10, 0, 32'h50, 32'h3, 32'h0);
        check("rst_mid_req_pre", 64'(data_req_o), 64'(1));
        rst_ni = 1'b0;
        #1;
        check("rst_mid_req_low", 64'(data_req_o), 64'(0));
        check("rst_mid_ready", 64'(ready_o), 64'(1));
        tick();
        rst_ni = 1'b1;
        tick();

        // 64-bit: SD @0x8, then LW @0xC
        q64.push_back({1'b0, 64'h0});
        valid_w = 1'b1; store_w = 1'b1; size_w = 2'b11; addr_w = 32'h8;
        wdata_w = 64'h1122_3344_5566_7788;
        tick();
        valid_w = 1'b0; store_w = 1'b0;
        check("sd64_req", 64'(req_w), 64'(1));
        check("sd64_addr", 64'(daddr_w), 64'h8);
        check("sd64_be", 64'(be_w), 64'hFF);
        check("sd64_wdata", dwdata_w, 64'h1122_3344_5566_7788);
        gnt_w = 1'b1;
        tick();
        gnt_w = 1'b0;
        tick();
        q64.push_back({1'b0, 64'hFFFF_FFFF_8000_0000});
        valid_w = 1'b1; load_w = 1'b1; size_w = 2'b10; addr_w = 32'hC;
        tick();
        valid_w = 1'b0; load_w = 1'b0;
        check("lw64_addr", 64'(daddr_w), 64'h8);
        check("lw64_be", 64'(be_w), 64'hF0);
        gnt_w = 1'b1;
        tick();
        gnt_w = 1'b0;
        rvalid_w = 1'b1;
        rdata_w  = 64'h8000_0000_0000_0000;
        tick();
        rvalid_w = 1'b0;
        tick();
        tick();

        check("q32_drained", 64'(q32.size()), 64'(0));
        check("q64_drained", 64'(q64.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
